// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle sequencer for a small RV32 subset (load, store,
// beq/bne, R-type). Fetches into ir, decodes the opcode, runs the memory
// handshakes and produces the datapath strobes. The optional ack-timeout
// watchdog is built only when SEQ_TIMEOUT_EN is defined.
module instr_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    input  logic                 alu_zero,
    output logic [31:0]          ir,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 alu_src_imm,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 timeout,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        WB_LD  = 3'd4,
        BRANCH = 3'd5,
        ALU_WB = 3'd6,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    state_t cur;
    logic   br_ok;
    logic   br_taken;
    logic   wait_expired;

    assign state = cur;

    // Only beq (000) and bne (001) are supported; bit 12 selects the inverted compare.
    assign br_ok    = (ir[14:13] == 2'b00);
    assign br_taken = br_ok & (ir[12] ? ~alu_zero : alu_zero);

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wait_cnt;
    logic       waiting;
    logic       ack_now;
    logic       timeout_flag;

    assign waiting      = (cur == FETCH) | (cur == MEM_RD) | (cur == MEM_WR);
    assign ack_now      = (cur == FETCH) ? imem_ack : dmem_ack;
    // The cycle that would make the count reach TIMEOUT_CYC is the last one tolerated.
    assign wait_expired = waiting & ~ack_now & (wait_cnt == WAIT_LAST);
    assign timeout      = timeout_flag;

    // Count unacknowledged cycles in a waiting state; any other cycle clears the count,
    // which is equivalent to clearing on entry because waits are only entered from elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (waiting && !ack_now) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (wait_expired) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYC;
    assign wait_expired       = 1'b0;
    assign timeout            = 1'b0;
`endif

    // State register, instruction register and sticky illegal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= FETCH;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            case (cur)
                FETCH: begin
                    if (imem_ack) begin
                        ir  <= imem_rdata;
                        cur <= DECODE;
                    end else if (wait_expired) begin
                        cur <= TRAP;
                    end
                end
                DECODE: begin
                    case (ir[6:0])
                        OP_LOAD:   cur <= MEM_RD;
                        OP_STORE:  cur <= MEM_WR;
                        OP_BRANCH: cur <= BRANCH;
                        OP_RTYPE:  cur <= ALU_WB;
                        default: begin
                            cur     <= TRAP;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                MEM_RD: begin
                    if (dmem_ack) begin
                        cur <= WB_LD;
                    end else if (wait_expired) begin
                        cur <= TRAP;
                    end
                end
                MEM_WR: begin
                    if (dmem_ack) begin
                        cur <= FETCH;
                    end else if (wait_expired) begin
                        cur <= TRAP;
                    end
                end
                WB_LD:  cur <= FETCH;
                ALU_WB: cur <= FETCH;
                BRANCH: begin
                    if (br_ok) begin
                        cur <= FETCH;
                    end else begin
                        cur     <= TRAP;
                        illegal <= 1'b1;
                    end
                end
                default: cur <= TRAP;
            endcase
        end
    end

    // Retired-instruction counter: one count per PC update, wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (pc_write) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

    // Strobe decode from the current state; only the store-ack PC update and the
    // branch outcome look at same-cycle inputs. imem_req is masked while reset is held.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        case (cur)
            FETCH: imem_req = ~reset;
            MEM_RD: begin
                dmem_req    = 1'b1;
                alu_src_imm = 1'b1;
            end
            MEM_WR: begin
                dmem_req    = 1'b1;
                dmem_we     = 1'b1;
                alu_src_imm = 1'b1;
                pc_write    = dmem_ack;
            end
            WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                pc_write   = 1'b1;
            end
            BRANCH: begin
                pc_write = br_ok;
                pc_src   = br_taken;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: directed bench for instr_seq_ctrl. A responder process serves
// memory requests with programmable ack delays; retirements are checked by a
// scoreboard monitor against expectations pushed when each instruction is issued.
module tb_instr_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        alu_zero;
    logic [31:0] ir;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        alu_src_imm;
    logic [2:0]  state;
    logic        illegal;
    logic        timeout;
    logic [31:0] instret;

    instr_seq_ctrl #(.TIMEOUT_CYC(4), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .ir(ir), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_imm(alu_src_imm),
        .state(state), .illegal(illegal), .timeout(timeout), .instret(instret)
    );

    typedef struct {
        logic        pc_src;
        logic        rw;
        logic        m2r;
        logic [31:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          retired = 0;
    logic [31:0] cfg_word = 32'h0;
    int          cfg_idly = 0;
    int          cfg_ddly = 0;
    int          trace[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Memory responder: inputs change just after the rising edge.
    initial begin
        int icnt;
        int dcnt;
        icnt = 0;
        dcnt = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        dmem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                imem_ack   = (icnt >= cfg_idly);
                imem_rdata = cfg_word;
                icnt++;
            end else begin
                imem_ack = 1'b0;
                icnt = 0;
            end
            if (dmem_req) begin
                dmem_ack = (dcnt >= cfg_ddly);
                dcnt++;
            end else begin
                dmem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    // Scoreboard monitor: every PC update must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pc_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 64'(pc_write), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc_src", 64'(pc_src), 64'(e.pc_src));
                    check("sb_reg_write", 64'(reg_write), 64'(e.rw));
                    check("sb_mem_to_reg", 64'(mem_to_reg), 64'(e.m2r));
                    check("sb_instret", 64'(instret), 64'(e.instret));
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 64'(state), 64'd0);
        check("rst_ir", 64'(ir), 64'd0);
        check("rst_instret", 64'(instret), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_reqs", 64'({imem_req, dmem_req, pc_write, reg_write}), 64'd0);
        reset = 1'b0;
        #1 check("rst_imem_req_first", 64'(imem_req), 64'd1);
        retired = 0;
    endtask

    task automatic run_instr(input string name, input logic [31:0] w, input int idly,
                             input int ddly, input logic z, input logic e_src,
                             input logic e_rw, input logic e_m2r, input int e_lat,
                             input int e_we);
        exp_t e;
        int   n;
        int   we_n;
        int   rw_n;
        bit   done;
        #1;
        cfg_word = w;
        cfg_idly = idly;
        cfg_ddly = ddly;
        alu_zero = z;
        e.pc_src  = e_src;
        e.rw      = e_rw;
        e.m2r     = e_m2r;
        e.instret = 32'(retired);
        exp_q.push_back(e);
        n = 0; we_n = 0; rw_n = 0; done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (n <= 8) trace[n-1] = int'(state);
            if (n == 1) check({name, "_instret_before"}, 64'(instret), 64'(retired));
            if (dmem_we) we_n++;
            if (reg_write) rw_n++;
            if (pc_write) done = 1;
        end
        retired++;
        check({name, "_retired"}, 64'(done), 64'd1);
        check({name, "_latency"}, 64'(n), 64'(e_lat));
        check({name, "_we_cycles"}, 64'(we_n), 64'(e_we));
        check({name, "_rw_cycles"}, 64'(rw_n), e_rw ? 64'd1 : 64'd0);
    endtask

    initial begin
        int n;
        int cnt;
        reset = 1'b1;
        alu_zero = 1'b0;
        apply_reset();

        // lw x1,0(x0): states FETCH, DECODE, MEM_RD, WB_LD
        run_instr("load", 32'h00002083, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0);
        check("load_trace0", 64'(trace[0]), 64'd0);
        check("load_trace1", 64'(trace[1]), 64'd1);
        check("load_trace2", 64'(trace[2]), 64'd2);
        check("load_trace3", 64'(trace[3]), 64'd4);
        // sw with data ack three cycles late: 4 cycles of dmem_we
        run_instr("store", 32'h00112023, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 6, 4);
        run_instr("beq_taken", 32'h00000463, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
        run_instr("beq_not", 32'h00000463, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
        run_instr("bne_taken", 32'h00001463, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        run_instr("bne_not", 32'h00001463, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        run_instr("rtype", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0);
        run_instr("load_slow", 32'h00002083, 2, 1, 1'b0, 1'b0, 1'b1, 1'b1, 7, 0);
        @(negedge clk);
        check("instret_total", 64'(instret), 64'd8);

        // Reset in the middle of a data read
        cfg_word = 32'h00002083; cfg_idly = 0; cfg_ddly = 5;
        n = 0;
        while (state !== 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrd_reached", 64'(state), 64'd2);
        #2 reset = 1'b1;
        #1;
        check("midrd_dmem_req", 64'(dmem_req), 64'd0);
        check("midrd_state", 64'(state), 64'd0);
        check("midrd_instret", 64'(instret), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        retired = 0;
        apply_reset();

        // Unsupported branch funct3 traps without a PC update
        #1;
        cfg_word = 32'h00002463; cfg_ddly = 0;
        n = 0; cnt = 0;
        while (state !== 3'd7 && n < 20) begin
            @(negedge clk);
            n++;
            if (pc_write) cnt++;
        end
        check("badbr_cycles", 64'(n), 64'd4);
        check("badbr_pc_write", 64'(cnt), 64'd0);
        check("badbr_illegal", 64'(illegal), 64'd1);
        apply_reset();

        // Unsupported opcode traps and stays quiet
        #1;
        cfg_word = 32'h0000007F;
        n = 0;
        while (state !== 3'd7 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("badop_cycles", 64'(n), 64'd3);
        check("badop_illegal", 64'(illegal), 64'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req || dmem_req || pc_write || reg_write || state !== 3'd7) cnt++;
        end
        check("badop_quiet_cycles", 64'(cnt), 64'd0);
        apply_reset();
        check("badop_cleared", 64'(illegal), 64'd0);

        // Fetch never acknowledged
        #1;
        cfg_idly = 100000;
`ifdef SEQ_TIMEOUT_EN
        n = 0;
        while (state !== 3'd7 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 64'(n), 64'd4);
        check("to_state", 64'(state), 64'd7);
        check("to_flag", 64'(timeout), 64'd1);
`else
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (state !== 3'd0) cnt++;
        end
        check("nto_left_fetch", 64'(cnt), 64'd0);
        check("nto_imem_req", 64'(imem_req), 64'd1);
        check("nto_flag", 64'(timeout), 64'd0);
`endif
        cfg_idly = 0;
        apply_reset();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
